// File: rtl/palette_scroller.sv
// Block-palette colouriser with a frame-driven scroll offset.
// Each pixel's block index, minus the scroll offset, is mapped to an RGB332 colour
// through a two-stage valid-qualified pipeline. The offset steps once every
// FRAME_DIV frame edges while scrolling is enabled.
module palette_scroller #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int BLOCK_SHIFT = 5,
  parameter int COLS        = 20,
  parameter int FRAME_DIV   = 6
) (
  input  logic           CLK_IN,
  input  logic           RST_IN,
  input  logic           FRAME_IN,
  input  logic           EN_IN,
  input  logic           DIR_IN,
  input  logic [1:0]     MODE_IN,
  input  logic           VALID_IN,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [7:0]     memRGB,
  output logic           VALID_OUT,
  output logic [7:0]     OFFSET_OUT
);

  localparam int PS_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(FRAME_DIV - 1);
  localparam logic [7:0]      COLS8   = 8'(COLS);

  localparam logic [1:0] MODE_LINEAR = 2'b00;
  localparam logic [1:0] MODE_HBARS  = 2'b01;
  localparam logic [1:0] MODE_VBARS  = 2'b10;

  // Spread the index bits across the colour fields: low bits drive red so that
  // neighbouring blocks differ most visibly.
  function automatic logic [7:0] pack_rgb(input logic [7:0] idx);
    return {idx[2:0], idx[5:3], idx[7:6]};
  endfunction

  logic            frame_q;
  logic            frame_edge;
  logic [PS_W-1:0] prescaler;
  logic [7:0]      offset;
  logic [7:0]      bx;
  logic [7:0]      by;
  logic [7:0]      idx_next;
  logic [7:0]      idx_p1;
  logic            vld_p1;
  logic [7:0]      rgb_p2;
  logic            vld_p2;

  assign frame_edge = FRAME_IN & ~frame_q;
  assign bx         = 8'(x >> BLOCK_SHIFT);
  assign by         = 8'(y >> BLOCK_SHIFT);

  // Frame-edge detector, prescaler and scroll offset; EN_IN low freezes both counters.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      frame_q   <= 1'b0;
      prescaler <= '0;
      offset    <= 8'd0;
    end else begin
      frame_q <= FRAME_IN;
      if (frame_edge && EN_IN) begin
        if (prescaler == PS_LAST) begin
          prescaler <= '0;
          offset    <= DIR_IN ? offset - 8'd1 : offset + 8'd1;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end
    end
  end

  // Per-pixel palette index; uses the offset as it stands before any update this cycle.
  always_comb begin
    idx_next = offset;
    case (MODE_IN)
      MODE_LINEAR: idx_next = COLS8 * by + bx - offset;
      MODE_HBARS:  idx_next = by - offset;
      MODE_VBARS:  idx_next = bx - offset;
      default:     idx_next = offset;
    endcase
  end

  // Pixel pipeline: index register then colour register, valid alongside.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      idx_p1 <= 8'd0;
      vld_p1 <= 1'b0;
      rgb_p2 <= 8'd0;
      vld_p2 <= 1'b0;
    end else begin
      // stage 1: block index
      idx_p1 <= idx_next;
      vld_p1 <= VALID_IN;
      // stage 2: colour
      rgb_p2 <= pack_rgb(idx_p1);
      vld_p2 <= vld_p1;
    end
  end

  assign memRGB     = rgb_p2;
  assign VALID_OUT  = vld_p2;
  assign OFFSET_OUT = offset;

endmodule

// File: tb/tb_palette_scroller.sv
// Directed bench for palette_scroller: reset, mapping, prescaler, wrap, pause,
// pattern modes, same-cycle offset update and mid-operation reset.
module tb_palette_scroller;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic       vin;
  logic [9:0] px;
  logic [9:0] py;
  logic [7:0] rgb;
  logic       vout;
  logic [7:0] offs;

  int checks = 0;
  int errors = 0;

  palette_scroller #(
    .X_W(10), .Y_W(10), .BLOCK_SHIFT(5), .COLS(20), .FRAME_DIV(6)
  ) dut (
    .CLK_IN    (clk),
    .RST_IN    (rst),
    .FRAME_IN  (frame),
    .EN_IN     (en),
    .DIR_IN    (dir),
    .MODE_IN   (mode),
    .VALID_IN  (vin),
    .x         (px),
    .y         (py),
    .memRGB    (rgb),
    .VALID_OUT (vout),
    .OFFSET_OUT(offs)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [1:0] s_mode [4];
  logic [9:0] s_x    [4];
  logic [9:0] s_y    [4];
  logic [7:0] s_exp  [4];

  initial begin
    // garbage on every input while reset is held
    rst = 1'b1; frame = 1'b1; en = 1'b1; dir = 1'b1; mode = 2'b10;
    vin = 1'b1; px = 10'h3a5; py = 10'h15a;
    tick();
    tick();
    check("reset_rgb",    rgb,         8'h00);
    check("reset_valid",  {7'd0, vout}, 8'h00);
    check("reset_offset", offs,        8'h00);
    rst = 1'b0; frame = 1'b0; dir = 1'b0; mode = 2'b00; vin = 1'b0;
    px = 10'd0; py = 10'd0;
    tick();

    // mapping: x=64,y=32 -> idx 22
    vin = 1'b1; px = 10'd64; py = 10'd32;
    tick();
    vin = 1'b0;
    check("map_valid_lat1", {7'd0, vout}, 8'h00);
    tick();
    check("map_valid_lat2", {7'd0, vout}, 8'h01);
    check("map_rgb",        rgb,          8'b110_010_00);
    tick();
    check("map_valid_drop", {7'd0, vout}, 8'h00);

    // prescaler: step every sixth edge
    en = 1'b1; dir = 1'b0;
    pulse(5);
    check("pre_5",  offs, 8'd0);
    pulse(1);
    check("pre_6",  offs, 8'd1);
    pulse(5);
    check("pre_11", offs, 8'd1);
    pulse(1);
    check("pre_12", offs, 8'd2);

    // wrap both ways
    do_reset();
    dir = 1'b1;
    pulse(5);
    check("wrap_dn_5", offs, 8'd0);
    pulse(1);
    check("wrap_dn_6", offs, 8'd255);
    dir = 1'b0;
    pulse(6);
    check("wrap_up_6", offs, 8'd0);

    // pause keeps prescaler and offset
    pulse(3);
    en = 1'b0;
    pulse(10);
    check("pause_hold", offs, 8'd0);
    en = 1'b1;
    pulse(2);
    check("pause_resume_2", offs, 8'd0);
    pulse(1);
    check("pause_resume_3", offs, 8'd1);

    // FRAME_IN high across reset release counts as one edge
    frame = 1'b1;
    do_reset();
    tick();
    frame = 1'b0;
    tick();
    pulse(4);
    check("rst_edge_5", offs, 8'd0);
    pulse(1);
    check("rst_edge_6", offs, 8'd1);

    // reach offset 5
    do_reset();
    pulse(30);
    check("offset_5", offs, 8'd5);

    // solid mode at several positions
    mode = 2'b11;
    vin = 1'b1; px = 10'd0;    py = 10'd0;    tick();
    px = 10'd1023; py = 10'd1023; tick();
    check("solid_a", rgb, 8'b101_000_00);
    px = 10'd317;  py = 10'd480;  tick();
    check("solid_b", rgb, 8'b101_000_00);
    vin = 1'b0; tick();
    check("solid_c", rgb, 8'b101_000_00);

    // back-to-back pixels in different modes at offset 5
    s_mode[0] = 2'b11; s_x[0] = 10'd0;    s_y[0] = 10'd0;    s_exp[0] = 8'b101_000_00;
    s_mode[1] = 2'b10; s_x[1] = 10'd64;   s_y[1] = 10'd900;  s_exp[1] = 8'b101_111_11;
    s_mode[2] = 2'b01; s_x[2] = 10'd999;  s_y[2] = 10'd224;  s_exp[2] = 8'b010_000_00;
    s_mode[3] = 2'b00; s_x[3] = 10'd1023; s_y[3] = 10'd1023; s_exp[3] = 8'b110_000_10;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        vin = 1'b1; mode = s_mode[i]; px = s_x[i]; py = s_y[i];
      end else begin
        vin = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        check($sformatf("stream_rgb_%0d", i - 1), rgb, s_exp[i - 1]);
        check($sformatf("stream_vld_%0d", i - 1), {7'd0, vout}, 8'h01);
      end else if (i == 5) begin
        check("stream_vld_end", {7'd0, vout}, 8'h00);
      end
    end

    // pixel coinciding with an offset step sees the old offset
    pulse(5);
    check("same_cycle_pre", offs, 8'd5);
    frame = 1'b1; vin = 1'b1; mode = 2'b11;
    tick();
    frame = 1'b0; vin = 1'b0;
    check("same_cycle_off", offs, 8'd6);
    tick();
    check("same_cycle_rgb", rgb, 8'b101_000_00);
    check("same_cycle_vld", {7'd0, vout}, 8'h01);

    // reset in the middle of streaming
    vin = 1'b1; px = 10'd100; py = 10'd100;
    tick();
    tick();
    check("mid_pre_vld", {7'd0, vout}, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_vld", {7'd0, vout}, 8'h00);
    check("mid_rst_off", offs, 8'd0);
    check("mid_rst_rgb", rgb, 8'h00);
    vin = 1'b0;
    tick();
    check("mid_rst_vld2", {7'd0, vout}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
